// File: rtl/mul_seq_pkg.sv
// Shared constants for the sequential add-based multiplier: FSM state encoding.
package mul_seq_pkg;

  localparam int ST_W = 2;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/mul_cntr.sv
// Loadable down-counter holding the remaining number of additions.
module mul_cntr #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic             dec,
  input  logic [WIDTH-1:0] d,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (ld) begin
      cnt_reg <= d;
    end else if (dec) begin
      cnt_reg <= cnt_reg - WIDTH'(1);
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/mul_seq_add.sv
// Sequential unsigned multiplier by repeated addition with valid/ready handshakes.
// PWIDTH is expected to be at least WIDTH; narrower products wrap and raise ovf.
module mul_seq_add
  import mul_seq_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int PWIDTH   = 2 * WIDTH,
  parameter int SWAP_MIN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a_in,
  input  logic [WIDTH-1:0]  b_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PWIDTH-1:0] product,
  output logic              ovf
);

  state_t state_reg, state_next;

  logic              ld;
  logic              dec;
  logic              cnt_zero;
  logic [WIDTH-1:0]  count_op;
  logic [WIDTH-1:0]  acc_op;
  logic [PWIDTH-1:0] acc_reg;
  logic [PWIDTH-1:0] p_reg;
  logic              ovf_reg;
  logic [PWIDTH:0]   sum;

  // On a tie the count operand is b_in; either choice gives the same count.
  generate
    if (SWAP_MIN != 0) begin : g_swap
      logic a_lt_b;
      assign a_lt_b   = (a_in < b_in);
      assign count_op = a_lt_b ? a_in : b_in;
      assign acc_op   = a_lt_b ? b_in : a_in;
    end else begin : g_noswap
      assign count_op = b_in;
      assign acc_op   = a_in;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (in_valid) state_next = ST_CALC;
      ST_CALC: if (cnt_zero) state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    ld        = 1'b0;
    dec       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        in_ready = 1'b1;
        ld       = in_valid;
      end
      ST_CALC: dec = ~cnt_zero;
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  mul_cntr #(
    .WIDTH(WIDTH)
  ) u_cntr (
    .clk  (clk),
    .rst_n(rst_n),
    .ld   (ld),
    .dec  (dec),
    .d    (count_op),
    .zero (cnt_zero)
  );

  // One extra bit catches the carry out of the product register.
  assign sum = {1'b0, p_reg} + {1'b0, acc_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
      p_reg   <= '0;
      ovf_reg <= 1'b0;
    end else if (ld) begin
      acc_reg <= PWIDTH'(acc_op);
      p_reg   <= '0;
      ovf_reg <= 1'b0;
    end else if (dec) begin
      p_reg   <= sum[PWIDTH-1:0];
      ovf_reg <= ovf_reg | sum[PWIDTH];
    end
  end

  assign product = p_reg;
  assign ovf     = ovf_reg;

endmodule

// File: tb/tb_mul_seq_add.sv
// Randomized self-checking bench: a full-width and a 16-bit-product instance share stimulus.
module tb_mul_seq_add;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] a_in;
  logic [15:0] b_in;

  logic        in_ready, out_valid, ovf;
  logic [31:0] product;
  logic        in_ready2, out_valid2, ovf2;
  logic [15:0] product2;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mul_seq_add #(.WIDTH(16), .PWIDTH(32), .SWAP_MIN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .ovf(ovf)
  );

  mul_seq_add #(.WIDTH(16), .PWIDTH(16), .SWAP_MIN(1)) dut_narrow (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid2), .out_ready(out_ready),
    .product(product2), .ovf(ovf2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference timeline: an accepted operation with count n completes n+1 edges later.
  longint      edge_no;
  int          m_phase;
  longint      m_due;
  logic [31:0] m_prod, m_res;
  logic        m_ovf, m_ovf_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase   <= 0;
      m_due     <= 0;
      m_prod    <= '0;
      m_ovf     <= 1'b0;
      m_res     <= '0;
      m_ovf_res <= 1'b0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_phase   <= 1;
          m_due     <= edge_no + 1 + longint'((a_in < b_in) ? a_in : b_in);
          m_res     <= 32'(a_in) * 32'(b_in);
          m_ovf_res <= (longint'(a_in) * longint'(b_in)) > 64'hFFFF_FFFF;
          m_prod    <= '0;
          m_ovf     <= 1'b0;
        end
        1: if (edge_no == m_due) begin
          m_phase <= 2;
          m_prod  <= m_res;
          m_ovf   <= m_ovf_res;
        end
        default: if (out_ready) m_phase <= 0;
      endcase
    end
  end

  always @(posedge clk) begin
    edge_no <= (edge_no === 64'bx) ? 64'd1 : edge_no + 1;
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("cyc in_ready", in_ready, m_phase == 0);
      chk("cyc out_valid", out_valid, m_phase == 2);
      if (m_phase != 1) begin
        chk("cyc product", product, m_prod);
        chk("cyc ovf", ovf, m_ovf);
      end
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold,
                        input logic [31:0] exp_p, input logic exp_o,
                        input logic [15:0] exp_p2, input logic exp_o2,
                        input int exp_lat, input string tag);
    int n;
    int lat;
    @(negedge clk);
    a_in     = a;
    b_in     = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk({tag, " accept timeout"}, 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'($urandom_range(0, 1));
    a_in     = 16'($urandom);
    b_in     = 16'($urandom);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      out_ready = out_valid ? 1'b0 : 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
    end while (!out_valid && lat < 70000);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " product"}, product, exp_p);
    chk({tag, " ovf"}, ovf, exp_o);
    chk({tag, " product16"}, product2, exp_p2);
    chk({tag, " ovf16"}, ovf2, exp_o2);
    repeat (hold) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'($urandom_range(0, 1));
      a_in      = 16'($urandom);
      @(posedge clk);
      #1;
      chk({tag, " held product"}, product, exp_p);
      chk({tag, " held out_valid"}, out_valid, 1);
      chk({tag, " held in_ready"}, in_ready, 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, " handoff in_ready"}, in_ready, 1);
    chk({tag, " handoff out_valid"}, out_valid, 0);
  endtask

  initial begin
    logic [15:0] ra, rb, t;
    logic [31:0] full;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset product", product, 0);
    chk("reset ovf", ovf, 0);
    chk("reset out_valid", out_valid, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset in_ready", in_ready, 1);

    run_op(16'd3, 16'd5, 0, 32'd15, 1'b0, 16'd15, 1'b0, 4, "t1");
    run_op(16'd5, 16'd3, 0, 32'd15, 1'b0, 16'd15, 1'b0, 4, "t1 swapped");
    run_op(16'd0, 16'hFFFF, 0, 32'd0, 1'b0, 16'd0, 1'b0, 1, "t2");
    run_op(16'd12, 16'd34, 10, 32'd408, 1'b0, 16'd408, 1'b0, 13, "t4 backpressure");

    // Reset in the middle of an operation.
    @(negedge clk);
    a_in     = 16'd200;
    b_in     = 16'd100;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("t5 mid product", product, 32'd4000);
    #1 rst_n = 1'b0;
    #1;
    chk("t5 reset product", product, 0);
    chk("t5 reset ovf", ovf, 0);
    chk("t5 reset out_valid", out_valid, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("t5 release in_ready", in_ready, 1);
    run_op(16'd7, 16'd6, 0, 32'd42, 1'b0, 16'd42, 1'b0, 7, "t5 after reset");

    run_op(16'd300, 16'd300, 0, 32'd90000, 1'b0, 16'h5F90, 1'b1, 301, "t6");
    run_op(16'd2, 16'd3, 0, 32'd6, 1'b0, 16'd6, 1'b0, 3, "t6 next");

    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom_range(0, 120));
      if (i % 7 == 3) ra = rb;
      if ($urandom_range(0, 1) == 1) begin
        t  = ra;
        ra = rb;
        rb = t;
      end
      full = 32'(ra) * 32'(rb);
      $display("random op %0d: %0d * %0d = %0d", i, ra, rb, full);
      run_op(ra, rb, $urandom_range(0, 3), full, 1'b0, full[15:0], full > 32'hFFFF,
             ((ra < rb) ? int'(ra) : int'(rb)) + 1, "rand");
    end

    run_op(16'hFFFF, 16'hFFFF, 0, 32'hFFFE0001, 1'b0, 16'h0001, 1'b1, 65536, "t3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
